// File: rtl/ic_fetch_stage.sv
// ic_fetch_stage: fetch sequencer behind the instruction-cache tile.
// Owns the fetch PC, decodes 16/32-bit instruction length from the tile's
// fetch window and queues fetch packets in a 2-entry in-order FIFO toward
// decode. Branch redirects flush the queue, and miss-stall cycles are counted.
module ic_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'hA000_0000,
  parameter int          MISS_CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [31:0]           regInPc,
  input  logic [47:0]           regOutPcVal,
  input  logic [1:0]            regOutPcOK,
  input  logic                  brRedirect,
  input  logic [31:0]           brTarget,
  input  logic                  idReady,
  output logic                  idValid,
  output logic [31:0]           idPc,
  output logic [31:0]           idInstr,
  output logic                  idLen32,
  output logic                  ifAlignFault,
  output logic [MISS_CNT_W-1:0] ifMissCnt
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd1;

  logic [31:0]           fetchPc;
  logic [1:0]            count;
  logic [31:0]           headPc, tailPc;
  logic [31:0]           headInstr, tailInstr;
  logic                  headLen32, tailLen32;
  logic                  alignFault;
  logic [MISS_CNT_W-1:0] missCnt;

  logic [15:0] hw0, hw1;
  logic        isLen32;
  logic [31:0] newInstr;
  logic        hit;
  logic        fifoFull;
  logic        popEn;
  logic        pushEn;
  logic        unusedBits;

  // The upper window halfword and the spare hit-flag bit carry nothing for us.
  assign unusedBits = ^{regOutPcVal[47:32], regOutPcOK[1]};

  // Length decode and push/pop decisions for the current tile answer.
  always_comb begin
    hw0      = regOutPcVal[15:0];
    hw1      = regOutPcVal[31:16];
    isLen32  = (hw0[15:12] == 4'h8) && (hw0[11:9] == 3'b111);
    newInstr = isLen32 ? {hw0, hw1} : {16'h0000, hw0};
    hit      = regOutPcOK[0];
    fifoFull = (count == 2'd2);
    popEn    = (count != 2'd0) && idReady;
    pushEn   = hit && !brRedirect && (!fifoFull || popEn);
  end

  // Fetch PC advances by the decoded length on a push; redirects override everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetchPc    <= RESET_PC_ALIGNED;
      alignFault <= 1'b0;
    end else begin
      alignFault <= 1'b0;
      if (brRedirect) begin
        fetchPc    <= brTarget & ~32'd1;
        alignFault <= brTarget[0];
      end else if (pushEn) begin
        fetchPc <= fetchPc + (isLen32 ? 32'd4 : 32'd2);
      end
    end
  end

  // Two-entry shifting FIFO: the head register feeds decode directly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= 2'd0;
      headPc    <= 32'd0;
      headInstr <= 32'd0;
      headLen32 <= 1'b0;
      tailPc    <= 32'd0;
      tailInstr <= 32'd0;
      tailLen32 <= 1'b0;
    end else if (brRedirect) begin
      count <= 2'd0;
    end else begin
      case ({pushEn, popEn})
        2'b10: begin
          if (count == 2'd0) begin
            headPc    <= fetchPc;
            headInstr <= newInstr;
            headLen32 <= isLen32;
          end else begin
            tailPc    <= fetchPc;
            tailInstr <= newInstr;
            tailLen32 <= isLen32;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          headPc    <= tailPc;
          headInstr <= tailInstr;
          headLen32 <= tailLen32;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            headPc    <= fetchPc;
            headInstr <= newInstr;
            headLen32 <= isLen32;
          end else begin
            headPc    <= tailPc;
            headInstr <= tailInstr;
            headLen32 <= tailLen32;
            tailPc    <= fetchPc;
            tailInstr <= newInstr;
            tailLen32 <= isLen32;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Saturating count of cycles spent waiting on a tile miss with room to accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      missCnt <= '0;
    end else if (!hit && !brRedirect && !fifoFull && (missCnt != '1)) begin
      missCnt <= missCnt + 1'b1;
    end
  end

  assign regInPc      = fetchPc;
  assign idValid      = (count != 2'd0);
  assign idPc         = headPc;
  assign idInstr      = headInstr;
  assign idLen32      = headLen32;
  assign ifAlignFault = alignFault;
  assign ifMissCnt    = missCnt;

endmodule

// File: tb/tb_ic_fetch_stage.sv
// tb_ic_fetch_stage: directed and randomized checks of ic_fetch_stage against
// a queue-based behavioural model of the fetch sequencer.
module tb_ic_fetch_stage;

  localparam int W = 4;
  localparam logic [31:0] RST_PC = 32'hA000_0000;

  logic         clock;
  logic         reset;
  logic [31:0]  regInPc;
  logic [47:0]  regOutPcVal;
  logic [1:0]   regOutPcOK;
  logic         brRedirect;
  logic [31:0]  brTarget;
  logic         idReady;
  logic         idValid;
  logic [31:0]  idPc;
  logic [31:0]  idInstr;
  logic         idLen32;
  logic         ifAlignFault;
  logic [W-1:0] ifMissCnt;

  ic_fetch_stage #(.RESET_PC(RST_PC), .MISS_CNT_W(W)) dut (
    .clock(clock), .reset(reset), .regInPc(regInPc),
    .regOutPcVal(regOutPcVal), .regOutPcOK(regOutPcOK),
    .brRedirect(brRedirect), .brTarget(brTarget), .idReady(idReady),
    .idValid(idValid), .idPc(idPc), .idInstr(idInstr), .idLen32(idLen32),
    .ifAlignFault(ifAlignFault), .ifMissCnt(ifMissCnt)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        len32;
  } pkt_t;

  pkt_t        mQ[$];
  logic [31:0] mPc;
  int          mMiss;
  logic        mFault;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mPc    = RST_PC & ~32'd1;
    mMiss  = 0;
    mFault = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".regInPc"}, 64'(regInPc), 64'(mPc));
    chk({tag, ".idValid"}, 64'(idValid), 64'(mQ.size() != 0));
    chk({tag, ".ifAlignFault"}, 64'(ifAlignFault), 64'(mFault));
    chk({tag, ".ifMissCnt"}, 64'(ifMissCnt), 64'(mMiss));
    if (mQ.size() != 0) begin
      chk({tag, ".idPc"}, 64'(idPc), 64'(mQ[0].pc));
      chk({tag, ".idInstr"}, 64'(idInstr), 64'(mQ[0].instr));
      chk({tag, ".idLen32"}, 64'(idLen32), 64'(mQ[0].len32));
    end
  endtask

  task automatic checkReset(input string tag);
    chk({tag, ".regInPc"}, 64'(regInPc), 64'(32'hA000_0000));
    chk({tag, ".idValid"}, 64'(idValid), 64'd0);
    chk({tag, ".idPc"}, 64'(idPc), 64'd0);
    chk({tag, ".idInstr"}, 64'(idInstr), 64'd0);
    chk({tag, ".idLen32"}, 64'(idLen32), 64'd0);
    chk({tag, ".ifAlignFault"}, 64'(ifAlignFault), 64'd0);
    chk({tag, ".ifMissCnt"}, 64'(ifMissCnt), 64'd0);
  endtask

  // One clock of stimulus: drive inputs, check the combinational PC, clock, update model, check.
  task automatic applyStimulus(input string tag, input logic hit, input logic [47:0] win,
                               input logic redir, input logic [31:0] tgt, input logic rdy);
    logic [15:0] h0, h1;
    logic        is32;
    logic        doPop, doPush, wasFull;
    pkt_t        p;
    regOutPcVal = win;
    regOutPcOK  = {1'b0, hit};
    brRedirect  = redir;
    brTarget    = tgt;
    idReady     = rdy;
    #1;
    chk({tag, ".pcPre"}, 64'(regInPc), 64'(mPc));
    @(posedge clock);
    h0   = win[15:0];
    h1   = win[31:16];
    is32 = (h0 >= 16'h8E00) && (h0 <= 16'h8FFF);
    doPop   = (mQ.size() > 0) && rdy;
    wasFull = (mQ.size() == 2);
    mFault  = 1'b0;
    if (redir) begin
      mQ.delete();
      mPc    = {tgt[31:1], 1'b0};
      mFault = tgt[0];
    end else begin
      doPush = hit && (!wasFull || doPop);
      if (doPop) void'(mQ.pop_front());
      if (doPush) begin
        p.pc    = mPc;
        p.instr = is32 ? {h0, h1} : {16'h0000, h0};
        p.len32 = is32;
        mQ.push_back(p);
        mPc = mPc + (is32 ? 32'd4 : 32'd2);
      end
      if (!hit && !wasFull && mMiss < (2 ** W) - 1) mMiss++;
    end
    #1;
    checkOutput(tag);
  endtask

  task automatic syncReset();
    reset = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    modelReset();
  endtask

  localparam logic [47:0] OP16 = 48'h0000_0000_6103;
  localparam logic [47:0] OP32 = 48'h0000_3456_8E12;
  localparam logic [47:0] MISSW = 48'h0;

  initial begin
    logic [47:0] rw;
    logic [15:0] rh0;
    reset       = 1'b1;
    regOutPcVal = '0;
    regOutPcOK  = '0;
    brRedirect  = 1'b0;
    brTarget    = '0;
    idReady     = 1'b0;
    modelReset();
    #3;
    checkReset("resetAsync");
    @(posedge clock);
    @(posedge clock);
    #1;
    checkReset("resetHeld");
    reset = 1'b0;

    // Sequential 16-bit fetch with decode always ready.
    applyStimulus("seq0", 1'b1, OP16, 1'b0, 32'h0, 1'b1);
    chk("seq0.valid", 64'(idValid), 64'd1);
    chk("seq0.instr", 64'(idInstr), 64'h6103);
    chk("seq0.len", 64'(idLen32), 64'd0);
    applyStimulus("seq1", 1'b1, OP16, 1'b0, 32'h0, 1'b1);
    applyStimulus("seq2", 1'b1, OP16, 1'b0, 32'h0, 1'b1);
    chk("seq2.pcNext", 64'(regInPc), 64'hA000_0006);

    // Even redirect, then a 32-bit instruction.
    applyStimulus("redirA", 1'b1, OP16, 1'b1, 32'hA000_0010, 1'b1);
    chk("redirA.valid", 64'(idValid), 64'd0);
    applyStimulus("op32", 1'b1, OP32, 1'b0, 32'h0, 1'b1);
    chk("op32.instr", 64'(idInstr), 64'h8E12_3456);
    chk("op32.len", 64'(idLen32), 64'd1);
    chk("op32.pcNext", 64'(regInPc), 64'hA000_0014);

    // Back-pressure: only two entries accepted, PC stalls on the third.
    applyStimulus("drain0", 1'b0, MISSW, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus("hold", 1'b1, OP16, 1'b0, 32'h0, 1'b0);
    chk("hold.pcStall", 64'(regInPc), 64'hA000_0018);
    chk("hold.headPc", 64'(idPc), 64'hA000_0014);
    applyStimulus("drain1", 1'b0, MISSW, 1'b0, 32'h0, 1'b1);
    chk("drain1.headPc", 64'(idPc), 64'hA000_0016);
    applyStimulus("drain2", 1'b0, MISSW, 1'b0, 32'h0, 1'b1);
    chk("drain2.valid", 64'(idValid), 64'd0);

    // Five miss cycles from a clean start, then a hit.
    syncReset();
    for (int i = 0; i < 5; i++) applyStimulus("miss", 1'b0, MISSW, 1'b0, 32'h0, 1'b1);
    chk("miss.cnt", 64'(ifMissCnt), 64'd5);
    chk("miss.pcHeld", 64'(regInPc), 64'hA000_0000);
    applyStimulus("missHit", 1'b1, OP16, 1'b0, 32'h0, 1'b1);
    chk("missHit.pc", 64'(idPc), 64'hA000_0000);

    // Redirect to an odd target while the FIFO is full and the tile hits.
    applyStimulus("fill0", 1'b1, OP16, 1'b0, 32'h0, 1'b0);
    applyStimulus("fill1", 1'b1, OP16, 1'b0, 32'h0, 1'b0);
    applyStimulus("redirOdd", 1'b1, OP32, 1'b1, 32'h8C00_0101, 1'b1);
    chk("redirOdd.valid", 64'(idValid), 64'd0);
    chk("redirOdd.fault", 64'(ifAlignFault), 64'd1);
    chk("redirOdd.pc", 64'(regInPc), 64'h8C00_0100);
    applyStimulus("afterRedir", 1'b0, MISSW, 1'b0, 32'h0, 1'b1);
    chk("afterRedir.fault", 64'(ifAlignFault), 64'd0);
    chk("afterRedir.valid", 64'(idValid), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rh0 = 16'($urandom);
      if ($urandom_range(0, 1) == 0) rh0[15:9] = 7'b1000111;
      rw = {16'($urandom), 16'($urandom), rh0};
      applyStimulus("rand", $urandom_range(0, 3) != 0, rw, $urandom_range(0, 19) == 0,
                    $urandom, $urandom_range(0, 3) != 0);
    end

    // Saturation of the miss counter, then reset in the middle of the burst.
    syncReset();
    for (int i = 0; i < 20; i++) applyStimulus("sat", 1'b0, MISSW, 1'b0, 32'h0, 1'b1);
    chk("sat.cnt", 64'(ifMissCnt), 64'hF);
    applyStimulus("satFill", 1'b1, OP32, 1'b0, 32'h0, 1'b0);
    applyStimulus("satMiss", 1'b0, MISSW, 1'b0, 32'h0, 1'b0);
    chk("satMiss.cnt", 64'(ifMissCnt), 64'hF);
    #1;
    reset = 1'b1;
    #1;
    checkReset("midReset");
    @(posedge clock);
    #2;
    reset = 1'b0;
    modelReset();
    applyStimulus("post", 1'b1, OP16, 1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ic_fetch_stage.md
Name: ic_fetch_stage

Overview:
- Fetch sequencer directly downstream of the instruction-cache tile.
- Owns the fetch PC and drives it to the tile, then consumes the tile's 48-bit fetch window and hit flag.
- Decodes instruction length (16/32-bit), advances the PC and queues decoded fetch packets in a 2-entry FIFO toward decode.
- Handles branch redirects and flushes, and counts miss-stall cycles.

Parameters:
- RESET_PC, 32'hA000_0000, fetch PC loaded on reset; bit 0 is forced to 0.
- MISS_CNT_W, 16, width of the saturating miss-cycle counter.

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- regInPc  out  32  fetch address to the I-cache tile; equals the fetchPc register
- regOutPcVal  in  48  fetch window from the tile; halfword 0 is bits [15:0]
- regOutPcOK  in  2  tile hit flag; bit 0 set means regOutPcVal is valid this cycle
- brRedirect  in  1  redirect request, one-cycle pulse
- brTarget  in  32  redirect target address
- idReady  in  1  decode accepts the head packet this cycle
- idValid  out  1  FIFO head is valid
- idPc  out  32  PC of the head instruction
- idInstr  out  32  head instruction word
- idLen32  out  1  head instruction is 32-bit
- ifAlignFault  out  1  one-cycle pulse: redirect target was odd
- ifMissCnt  out  MISS_CNT_W  saturating count of cycles with a valid fetch PC and no hit

Behaviour:
- Reset (async) values:
  - fetchPc = RESET_PC & ~1
  - FIFO count = 0, so idValid = 0; idPc, idInstr, idLen32 = 0
  - ifAlignFault = 0, ifMissCnt = 0
- Tile timing: the tile answers combinationally on regInPc, so a hit is consumed in the same cycle fetchPc is presented. Latency from fetchPc to FIFO entry is 1 clock. Latency from a hit to idValid is 1 clock when the FIFO is empty.
- Length decode, with hw0 = regOutPcVal[15:0] and hw1 = regOutPcVal[31:16]:
  - 32-bit iff hw0[15:12] == 4'h8 and hw0[11:9] == 3'b111; otherwise 16-bit.
  - 16-bit entry: instr = {16'h0000, hw0}.
  - 32-bit entry: instr = {hw0, hw1}, first halfword in the upper half.
  - regOutPcVal[47:32] is ignored.
- Push rule: push when regOutPcOK[0] = 1, no redirect this cycle, and (count < 2, or count == 2 with pop this cycle).
  - On push: entry = {fetchPc, instr, len32}; fetchPc <= fetchPc + (len32 ? 4 : 2), 32-bit wrap-around permitted.
- No push (miss, or FIFO full without pop): fetchPc holds.
- Pop rule: pop when idValid and idReady. The head advances and the FIFO stays in order. Simultaneous push and pop leaves count unchanged.
- Redirect has the highest priority.
  - fetchPc <= brTarget & ~1. FIFO is cleared (count = 0); any pop and any hit in the same cycle are discarded.
  - ifAlignFault <= brTarget[0] for exactly one cycle.
  - The first fetch from the new PC occurs in the next cycle.
- Miss counter: increments when regOutPcOK[0] = 0, no redirect, and the FIFO is not full. It saturates at all-ones and is cleared only by reset.
- Outputs are driven from FIFO-head registers. idPc, idInstr and idLen32 hold their value while idValid = 1 and idReady = 0.
- Reset asserted mid-operation clears all state immediately. Outstanding tile misses need no cancellation because the tile re-evaluates from regInPc.

Test Plan:
- Reset, then release, with the tile always hitting 16-bit ops (hw0 = 16'h6103) and idReady = 1:
  - regInPc = A000_0000, A000_0002, A000_0004 on successive cycles.
  - idValid rises 1 clock after the first hit; idInstr = 0000_6103, idLen32 = 0.
- At PC A000_0010, window hw0 = 8E12, hw1 = 3456:
  - idInstr = 8E12_3456, idLen32 = 1.
  - Next regInPc = A000_0014.
- Hold idReady = 0 with continuous hits:
  - Exactly 2 entries are accepted and regInPc stalls at the third PC.
  - Raise idReady: the entries drain in order with no loss or duplicate.
- Tile misses for 5 cycles, then hits:
  - ifMissCnt = 5, regInPc is held throughout, and the packet appears after the hit.
- FIFO full plus a hit, with brRedirect = 1 and brTarget = 8C00_0101 in the same cycle:
  - FIFO empties (idValid = 0 next cycle) and ifAlignFault pulses for 1 cycle.
  - regInPc = 8C00_0100; the hit of that cycle is not queued.
- Force the miss counter to the saturation boundary (MISS_CNT_W = 4, 20 miss cycles):
  - ifMissCnt = 4'hF and does not wrap.
  - Assert reset mid-burst: all outputs return to their reset values asynchronously.
